// File: rtl/cir_reg_w_ctrl.sv
// Load/rotate sequencer for one PE's K_H x K_W circular weight register.
// Optional feature macro: CIR_W_CTRL_STALL_CNT_EN adds stall_cnt (RUN cycles without pe_ready).
module cir_reg_w_ctrl #(
  parameter int K_H   = 3,
  parameter int K_W   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_out,
  input  logic             w_valid,
  input  logic [K_H*8-1:0] w_data,
  output logic             w_ready,
  input  logic             pe_ready,
  output logic             clear,
  output logic             load_en,
  output logic [K_H*8-1:0] in_data,
  output logic             shift,
  output logic             busy,
  output logic             done
`ifdef CIR_W_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int COL_W = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic               clear_q;
  logic               load_en_q;
  logic [K_H*8-1:0]   in_data_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [COL_W-1:0]   col_cnt_q;
  logic [CNT_W-1:0]   out_left_q;

  logic start_acc;
  logic w_hs;
  logic last_beat_loaded;

  assign start_acc        = (state_q == S_IDLE) && start && !abort;
  // w_ready is masked by abort so no beat is consumed in the cycle the job is torn down.
  assign w_ready          = (state_q == S_LOAD) && (beat_cnt_q < CNT_W'(K_W)) && !abort;
  assign w_hs             = w_valid && w_ready;
  assign last_beat_loaded = load_en_q && (beat_cnt_q == CNT_W'(K_W));

  assign shift   = (state_q == S_RUN) && pe_ready;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign clear   = clear_q;
  assign load_en = load_en_q;
  assign in_data = in_data_q;

  // NOTE: every register here updates with <= so all of them see the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clear_q    <= 1'b0;
      load_en_q  <= 1'b0;
      in_data_q  <= '0;
      beat_cnt_q <= '0;
      col_cnt_q  <= '0;
      out_left_q <= '0;
    end else begin
      clear_q   <= 1'b0;
      load_en_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        clear_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_acc) begin
              state_q    <= S_CLEAR;
              clear_q    <= 1'b1;
              out_left_q <= num_out;
              beat_cnt_q <= '0;
              col_cnt_q  <= '0;
            end
          end
          S_CLEAR: begin
            state_q    <= S_LOAD;
            beat_cnt_q <= '0;
          end
          S_LOAD: begin
            if (w_hs) begin
              load_en_q  <= 1'b1;
              in_data_q  <= w_data;
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
            // Leave only after the final load strobe has been presented to the register.
            if (last_beat_loaded) begin
              col_cnt_q <= '0;
              state_q   <= (out_left_q == '0) ? S_DONE : S_RUN;
            end
          end
          S_RUN: begin
            if (pe_ready) begin
              if (col_cnt_q == COL_W'(K_W - 1)) begin
                col_cnt_q  <= '0;
                out_left_q <= out_left_q - CNT_W'(1);
                if (out_left_q == CNT_W'(1)) state_q <= S_DONE;
              end else begin
                col_cnt_q <= col_cnt_q + COL_W'(1);
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CIR_W_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_RUN) && !pe_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cir_reg_w_ctrl.sv
// Self-checking bench for cir_reg_w_ctrl: table of whole jobs plus hand-written abort/reset sequences.
// Loaded column beats go through a scoreboard queue and are matched against load_en/in_data.
module tb_cir_reg_w_ctrl;
  localparam int K_H   = 3;
  localparam int K_W   = 3;
  localparam int CNT_W = 16;
  localparam int DW    = K_H * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_out = '0;
  logic             w_valid = 1'b0;
  logic [DW-1:0]    w_data = '0;
  logic             w_ready;
  logic             pe_ready = 1'b0;
  logic             clear;
  logic             load_en;
  logic [DW-1:0]    in_data;
  logic             shift;
  logic             busy;
  logic             done;
`ifdef CIR_W_CTRL_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  cir_reg_w_ctrl #(.K_H(K_H), .K_W(K_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .num_out  (num_out),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .pe_ready (pe_ready),
    .clear    (clear),
    .load_en  (load_en),
    .in_data  (in_data),
    .shift    (shift),
    .busy     (busy),
    .done     (done)
`ifdef CIR_W_CTRL_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [CNT_W-1:0] num;
    logic [31:0]      wv;          // w_valid per cycle since start (bit c), 1 beyond 31
    logic [31:0]      pr;          // pe_ready per cycle since start
    int               busy_start;  // cycle of an extra start pulse while busy, -1 none
    int               exp_wready;
    int               exp_done;    // cycle index of the done pulse
    int               exp_stall;
  } job_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  job_t  jobs[6];
  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input job_t j, input string tag);
    int n_clear = 0, clear_cyc = -1, n_load = 0, n_shift = 0, n_done = 0;
    int done_cyc = -1, n_wr = 0, n_busy = 0, excl_bad = 0, early_shift = 0;
    bit seen_done = 1'b0;
    beat_t b;
    sb.delete();
    for (int c = 0; c < 200 && !seen_done; c++) begin
      start    = (c == 0) || (c == j.busy_start);
      num_out  = (c == 0) ? j.num : CNT_W'(c + 7);
      w_valid  = (c < 32) ? j.wv[c] : 1'b1;
      pe_ready = (c < 32) ? j.pr[c] : 1'b1;
      w_data   = DW'($urandom);
      @(negedge clk);
      if (int'(clear) + int'(load_en) + int'(shift) > 1) excl_bad++;
      if (clear) begin n_clear++; clear_cyc = c; end
      if (w_ready) n_wr++;
      if (busy) n_busy++;
      if (load_en) begin
        n_load++;
        check({tag, " sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          b = sb.pop_front();
          check({tag, " in_data"}, in_data, b.data);
          check({tag, " load_lat"}, c, b.cyc + 1);
        end
      end
      if (shift) begin
        n_shift++;
        if (n_load < K_W) early_shift++;
      end
      if (done) begin n_done++; done_cyc = c; seen_done = 1'b1; end
      if (w_valid && w_ready) sb.push_back('{w_data, c});
      tick();
    end
    check({tag, " done_seen"}, seen_done, 1'b1);
    check({tag, " n_clear"}, n_clear, 1);
    check({tag, " clear_cyc"}, clear_cyc, 1);
    check({tag, " n_load"}, n_load, K_W);
    check({tag, " n_shift"}, n_shift, j.num * K_W);
    check({tag, " n_done"}, n_done, 1);
    check({tag, " done_cyc"}, done_cyc, j.exp_done);
    check({tag, " n_wready"}, n_wr, j.exp_wready);
    check({tag, " n_busy"}, n_busy, j.exp_done);
    check({tag, " exclusive"}, excl_bad, 0);
    check({tag, " early_shift"}, early_shift, 0);
    check({tag, " sb_drained"}, sb.size(), 0);
`ifdef CIR_W_CTRL_STALL_CNT_EN
    check({tag, " stall_cnt"}, stall_cnt, j.exp_stall);
`endif
    start = 1'b0; w_valid = 1'b0; pe_ready = 1'b0;
    @(negedge clk);
    check({tag, " idle_busy"}, busy, 1'b0);
    check({tag, " done_pulse"}, done, 1'b0);
`ifdef CIR_W_CTRL_STALL_CNT_EN
    check({tag, " stall_hold"}, stall_cnt, j.exp_stall);
`endif
    tick();
  endtask

  int ns;
  int nd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    //           num     w_valid       pe_ready      bstart wr  done stall
    jobs[0] = '{16'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1,    3,  12,  0};
    jobs[1] = '{16'd2, 32'hFFFF_FF55, 32'hFFFF_FFFF, -1,    5,  14,  0};
    jobs[2] = '{16'd1, 32'hFFFF_FFFF, 32'hFFFF_FE7F, -1,    3,  11,  2};
    jobs[3] = '{16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1,    3,  6,   0};
    jobs[4] = '{16'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1,    3,  15,  0};
    jobs[5] = '{16'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,     3,  9,   0};

    #12;
    check("rst clear", clear, 1'b0);
    check("rst load_en", load_en, 1'b0);
    check("rst in_data", in_data, '0);
    check("rst shift", shift, 1'b0);
    check("rst w_ready", w_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
`ifdef CIR_W_CTRL_STALL_CNT_EN
    check("rst stall_cnt", stall_cnt, '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_job(jobs[i], $sformatf("job%0d", i));
    run_job(jobs[1], "job1_again");

    // abort and start together in IDLE: abort wins, nothing starts
    start = 1'b1; abort = 1'b1; num_out = 16'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start busy", busy, 1'b0);
    check("abort_start clear", clear, 1'b0);
    tick();

    // abort during RUN after 4 of 6 shifts
    ns = 0;
    start = 1'b1; num_out = 16'd2; w_valid = 1'b1; pe_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (shift) ns++;
      tick();
      start = 1'b0;
    end
    check("abort_run shifts_before", ns, 4);
    abort = 1'b1; pe_ready = 1'b0;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_run clear", clear, 1'b1);
    check("abort_run busy", busy, 1'b0);
    check("abort_run done", done, 1'b0);
    check("abort_run shift", shift, 1'b0);
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("abort_run quiet", nd, 0);
    tick();
    run_job(jobs[0], "after_abort");

    // abort during LOAD while a beat is offered: not accepted, no load follows
    start = 1'b1; num_out = 16'd2; w_valid = 1'b1; pe_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_load w_ready", w_ready, 1'b0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_load load_en", load_en, 1'b0);
    check("abort_load clear", clear, 1'b1);
    check("abort_load busy", busy, 1'b0);
    tick();

    // asynchronous reset mid-LOAD
    start = 1'b1; num_out = 16'd2; w_valid = 1'b1; pe_ready = 1'b1; w_data = 24'hA5_C3_5A;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rst_mid load_en_before", load_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid clear", clear, 1'b0);
    check("rst_mid load_en", load_en, 1'b0);
    check("rst_mid in_data", in_data, '0);
    check("rst_mid shift", shift, 1'b0);
    check("rst_mid w_ready", w_ready, 1'b0);
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid done", done, 1'b0);
    w_valid = 1'b0; pe_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_job(jobs[2], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
